// File: rtl/arrow_spawn_scheduler.sv
// Round-robin spawn scheduler for the four arrow lanes: threshold-qualifies
// LFSR values on game ticks, applies per-lane cooldown, and offers one spawn at a time.
module arrow_spawn_scheduler #(
  parameter logic [12:0] THRESHOLD = 13'd512,
  parameter logic [7:0]  COOLDOWN  = 8'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        run,
  input  logic [12:0] d_rand,
  input  logic [12:0] u_rand,
  input  logic [12:0] l_rand,
  input  logic [12:0] r_rand,
  input  logic        spawn_ready,
  output logic        spawn_valid,
  output logic [1:0]  spawn_lane,
  output logic [3:0]  pending,
  output logic [15:0] spawn_count,
  output logic [7:0]  drop_count
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t      state_r, state_next_s;
  logic [1:0]  lane_r, rr_ptr_r;
  logic [3:0]  pending_r, pending_next_s, req_s, grant_s;
  logic [15:0] spawn_count_r;
  logic [7:0]  drop_count_r;
  logic [7:0]  cooldown_r [4];
  logic [12:0] rand_s [4];
  logic [2:0]  pick_s, drop_inc_s;
  logic        accept_s;

  // Returns {found, lane}: first pending lane at or after ptr, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] pend, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (pend[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {6'b000000, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  assign rand_s[0] = d_rand;
  assign rand_s[1] = u_rand;
  assign rand_s[2] = l_rand;
  assign rand_s[3] = r_rand;

  assign accept_s = (state_r == OFFER) && spawn_ready;
  assign grant_s  = accept_s ? (4'b0001 << lane_r) : 4'b0000;
  assign pick_s   = rr_pick(pending_r, rr_ptr_r);

  // Per-lane request qualification, pending update (incl. run=0 flush) and drop count.
  always_comb begin
    req_s          = 4'b0000;
    pending_next_s = pending_r;
    drop_inc_s     = 3'd0;
    for (int i = 0; i < 4; i++) begin
      // The granted lane's request is swallowed: its cooldown loads on this edge.
      req_s[i] = tick && run && (rand_s[i] < THRESHOLD) && (cooldown_r[i] == 8'd0) && !grant_s[i];
      if (!run) begin
        pending_next_s[i] = pending_r[i] && (state_r == OFFER) && (lane_r == 2'(i)) && !accept_s;
      end else if (grant_s[i]) begin
        pending_next_s[i] = 1'b0;
      end else if (req_s[i]) begin
        pending_next_s[i] = 1'b1;
      end else begin
        pending_next_s[i] = pending_r[i];
      end
      if (req_s[i] && pending_r[i]) begin
        drop_inc_s = drop_inc_s + 3'd1;
      end else begin
        drop_inc_s = drop_inc_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // FSM next-state logic; a new offer only starts while the game runs.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = (run && pick_s[2]) ? OFFER : IDLE;
      OFFER:   state_next_s = spawn_ready ? IDLE : OFFER;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    spawn_valid = 1'b0;
    case (state_r)
      IDLE:    spawn_valid = 1'b0;
      OFFER:   spawn_valid = 1'b1;
      default: spawn_valid = 1'b0;
    endcase
  end

  // Datapath registers: offered lane, pending flags, rr pointer, cooldowns, statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_r        <= 2'd0;
      rr_ptr_r      <= 2'd0;
      pending_r     <= 4'b0000;
      spawn_count_r <= 16'd0;
      drop_count_r  <= 8'd0;
      for (int i = 0; i < 4; i++) cooldown_r[i] <= 8'd0;
    end else begin
      pending_r    <= pending_next_s;
      drop_count_r <= sat_add8(drop_count_r, drop_inc_s);
      if ((state_r == IDLE) && (state_next_s == OFFER)) lane_r <= pick_s[1:0];
      if (accept_s) begin
        rr_ptr_r      <= lane_r + 2'd1;
        spawn_count_r <= spawn_count_r + 16'd1;
      end
      for (int i = 0; i < 4; i++) begin
        if (grant_s[i])                             cooldown_r[i] <= COOLDOWN;
        else if (tick && (cooldown_r[i] != 8'd0))   cooldown_r[i] <= cooldown_r[i] - 8'd1;
      end
    end
  end

  assign spawn_lane  = lane_r;
  assign pending     = pending_r;
  assign spawn_count = spawn_count_r;
  assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_arrow_spawn_scheduler.sv
// Directed, table-driven bench for arrow_spawn_scheduler plus hand-written
// sequences for saturation, same-cycle accept+tick, run flush and async reset.
module tb_arrow_spawn_scheduler;

  localparam logic [12:0] H = 13'h1FFF;
  localparam logic [12:0] Z = 13'd0;

  logic        clk, rst, tick, run, spawn_ready;
  logic [12:0] d_rand, u_rand, l_rand, r_rand;
  logic        spawn_valid;
  logic [1:0]  spawn_lane;
  logic [3:0]  pending;
  logic [15:0] spawn_count;
  logic [7:0]  drop_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rs, tk, rn;
    logic [12:0] d, u, l, r;
    logic        rdy;
    logic        ev;
    logic [1:0]  el;
    logic [3:0]  ep;
    logic [15:0] esc;
    logic [7:0]  edc;
  } vec_t;

  vec_t tbl[$];

  arrow_spawn_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .run(run),
    .d_rand(d_rand), .u_rand(u_rand), .l_rand(l_rand), .r_rand(r_rand),
    .spawn_ready(spawn_ready), .spawn_valid(spawn_valid), .spawn_lane(spawn_lane),
    .pending(pending), .spawn_count(spawn_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rs, tk, rn, input logic [12:0] d, u, l, r, input logic rdy,
                     input logic ev, input logic [1:0] el, input logic [3:0] ep,
                     input logic [15:0] esc, input logic [7:0] edc);
    vec_t v;
    v.rs = rs; v.tk = tk; v.rn = rn; v.d = d; v.u = u; v.l = l; v.r = r; v.rdy = rdy;
    v.ev = ev; v.el = el; v.ep = ep; v.esc = esc; v.edc = edc;
    tbl.push_back(v);
  endtask

  // Drive one cycle on the falling edge, then land 1ns after the rising edge.
  task automatic cyc(input logic rs, tk, rn, input logic [12:0] d, u, l, r, input logic rdy);
    @(negedge clk);
    rst = rs; tick = tk; run = rn; d_rand = d; u_rand = u; l_rand = l; r_rand = r;
    spawn_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic ev, input logic [1:0] el, input logic [3:0] ep,
                     input logic [15:0] esc, input logic [7:0] edc);
    checks++;
    if (spawn_valid !== ev) begin
      failures++;
      $display("FAIL %s spawn_valid got=%0b want=%0b", nm, spawn_valid, ev);
    end
    if (ev) begin
      checks++;
      if (spawn_lane !== el) begin
        failures++;
        $display("FAIL %s spawn_lane got=%0d want=%0d", nm, spawn_lane, el);
      end
    end
    checks++;
    if (pending !== ep) begin
      failures++;
      $display("FAIL %s pending got=%b want=%b", nm, pending, ep);
    end
    checks++;
    if (spawn_count !== esc) begin
      failures++;
      $display("FAIL %s spawn_count got=%0d want=%0d", nm, spawn_count, esc);
    end
    checks++;
    if (drop_count !== edc) begin
      failures++;
      $display("FAIL %s drop_count got=%0d want=%0d", nm, drop_count, edc);
    end
  endtask

  initial begin
    logic [3:0] all;
    all = 4'hF;
    rst = 1'b1; tick = 1'b0; run = 1'b0; spawn_ready = 1'b0;
    d_rand = H; u_rand = H; l_rand = H; r_rand = H;

    // Reset and idle: high rand values never request.
    add(1,0,1,H,H,H,H,0, 0,0,4'h0,16'd0,8'd0);
    add(0,1,1,H,H,H,H,1, 0,0,4'h0,16'd0,8'd0);
    add(0,1,1,H,H,H,H,0, 0,0,4'h0,16'd0,8'd0);
    // Single lane: offer one cycle after tick, accept, then cooldown of 8.
    add(0,1,1,Z,H,H,H,1, 0,0,4'h1,16'd0,8'd0);
    add(0,0,1,Z,H,H,H,1, 1,0,4'h1,16'd0,8'd0);
    add(0,0,1,Z,H,H,H,1, 0,0,4'h0,16'd1,8'd0);
    add(0,1,1,Z,H,H,H,1, 0,0,4'h0,16'd1,8'd0);
    for (int k = 0; k < 7; k++) add(0,1,1,Z,H,H,H,0, 0,0,4'h0,16'd1,8'd0);
    add(0,1,1,Z,H,H,H,0, 0,0,4'h1,16'd1,8'd0);
    add(0,0,1,H,H,H,H,0, 1,0,4'h1,16'd1,8'd0);
    add(0,0,1,H,H,H,H,1, 0,0,4'h0,16'd2,8'd0);
    // Round-robin fairness with ready always high.
    add(1,0,1,H,H,H,H,0, 0,0,4'h0,16'd0,8'd0);
    add(0,1,1,Z,Z,Z,Z,1, 0,0,4'hF,16'd0,8'd0);
    for (int k = 0; k < 4; k++) begin
      add(0,0,1,Z,Z,Z,Z,1, 1,2'(k),4'(all << k),16'(k),8'd0);
      add(0,0,1,Z,Z,Z,Z,1, 0,2'(k),4'(all << (k+1)),16'(k+1),8'd0);
    end
    for (int k = 0; k < 8; k++) add(0,1,1,Z,Z,Z,Z,0, 0,0,4'h0,16'd4,8'd0);
    add(0,1,1,Z,Z,Z,Z,0, 0,0,4'hF,16'd4,8'd0);
    add(0,0,1,Z,Z,Z,Z,0, 1,0,4'hF,16'd4,8'd0);
    // Backpressure: 3 ticks with ready low, 8 drops, then drain.
    add(1,0,1,H,H,H,H,0, 0,0,4'h0,16'd0,8'd0);
    add(0,1,1,Z,Z,Z,Z,0, 0,0,4'hF,16'd0,8'd0);
    add(0,0,1,Z,Z,Z,Z,0, 1,0,4'hF,16'd0,8'd0);
    add(0,1,1,Z,Z,Z,Z,0, 1,0,4'hF,16'd0,8'd4);
    add(0,0,1,Z,Z,Z,Z,0, 1,0,4'hF,16'd0,8'd4);
    add(0,1,1,Z,Z,Z,Z,0, 1,0,4'hF,16'd0,8'd8);
    for (int k = 0; k < 4; k++) begin
      add(0,0,1,H,H,H,H,1, 0,2'(k),4'(all << (k+1)),16'(k+1),8'd8);
      if (k < 3) add(0,0,1,H,H,H,H,1, 1,2'(k+1),4'(all << (k+1)),16'(k+1),8'd8);
    end

    foreach (tbl[i]) begin
      cyc(tbl[i].rs, tbl[i].tk, tbl[i].rn, tbl[i].d, tbl[i].u, tbl[i].l, tbl[i].r, tbl[i].rdy);
      chk($sformatf("vec%0d", i), tbl[i].ev, tbl[i].el, tbl[i].ep, tbl[i].esc, tbl[i].edc);
    end

    // Same-cycle accept + tick on the granted lane: no drop, full cooldown loaded.
    cyc(1,0,1,H,H,H,H,0);
    cyc(0,1,1,Z,H,H,H,0);
    cyc(0,0,1,Z,H,H,H,0);
    chk("acc_tick_offer", 1'b1, 2'd0, 4'h1, 16'd0, 8'd0);
    cyc(0,1,1,Z,H,H,H,1);
    chk("acc_tick", 1'b0, 2'd0, 4'h0, 16'd1, 8'd0);
    for (int k = 0; k < 8; k++) cyc(0,1,1,Z,H,H,H,0);
    chk("acc_tick_cd8", 1'b0, 2'd0, 4'h0, 16'd1, 8'd0);
    cyc(0,1,1,Z,H,H,H,0);
    chk("acc_tick_cd9", 1'b0, 2'd0, 4'h1, 16'd1, 8'd0);

    // Drop counter saturation: 4 drops per tick, 252 -> 255 instead of 256.
    cyc(1,0,1,H,H,H,H,0);
    cyc(0,1,1,Z,Z,Z,Z,0);
    cyc(0,0,1,Z,Z,Z,Z,0);
    for (int k = 0; k < 63; k++) cyc(0,1,1,Z,Z,Z,Z,0);
    chk("drop_252", 1'b1, 2'd0, 4'hF, 16'd0, 8'd252);
    for (int k = 0; k < 6; k++) cyc(0,1,1,Z,Z,Z,Z,0);
    chk("drop_sat", 1'b1, 2'd0, 4'hF, 16'd0, 8'd255);

    // run=0 flush keeps only the offered lane, which is still accepted.
    cyc(1,0,1,H,H,H,H,0);
    cyc(0,1,1,Z,Z,Z,Z,0);
    cyc(0,0,1,Z,Z,Z,Z,0);
    chk("flush_offer", 1'b1, 2'd0, 4'hF, 16'd0, 8'd0);
    cyc(0,1,0,Z,Z,Z,Z,0);
    chk("flush_a", 1'b1, 2'd0, 4'h1, 16'd0, 8'd0);
    cyc(0,1,0,Z,Z,Z,Z,0);
    chk("flush_b", 1'b1, 2'd0, 4'h1, 16'd0, 8'd0);
    cyc(0,0,0,Z,Z,Z,Z,1);
    chk("flush_acc", 1'b0, 2'd0, 4'h0, 16'd1, 8'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(0,1,0,Z,Z,Z,Z,1);
      chk($sformatf("flush_idle%0d", k), 1'b0, 2'd0, 4'h0, 16'd1, 8'd0);
    end

    // Async reset mid-offer clears outputs without a clock edge.
    cyc(0,1,1,H,Z,H,H,0);
    cyc(0,0,1,H,H,H,H,0);
    chk("async_pre", 1'b1, 2'd1, 4'h2, 16'd1, 8'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 1'b0, 2'd0, 4'h0, 16'd0, 8'd0);
    checks++;
    if (spawn_lane !== 2'd0) begin
      failures++;
      $display("FAIL async_rst spawn_lane got=%0d want=0", spawn_lane);
    end
    #1 rst = 1'b0;
    cyc(0,1,1,H,H,H,H,1);
    chk("post_rst_idle", 1'b0, 2'd0, 4'h0, 16'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
